// File: rtl/fir_pkg.sv
// Shared defaults and loader state encoding for the FIR input stage.
package fir_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_COEF_W   = 16;
    localparam int DEF_NUM_COEF = 4;
    localparam int DEF_DEPTH    = 8;

    typedef enum logic {
        COEF_LOAD  = 1'b0,
        COEF_READY = 1'b1
    } coef_state_t;
endpackage

// File: rtl/sample_fifo_ram.sv
// Sample storage: one synchronous write port, one asynchronous read port.
module sample_fifo_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fir_input_stage.sv
// Show-ahead sample FIFO plus serial coefficient loader feeding the multiplier FSM.
module fir_input_stage #(
    parameter int DATA_W   = fir_pkg::DEF_DATA_W,
    parameter int COEF_W   = fir_pkg::DEF_COEF_W,
    parameter int NUM_COEF = fir_pkg::DEF_NUM_COEF,
    parameter int DEPTH    = fir_pkg::DEF_DEPTH,
    localparam int CNT_W   = $clog2(DEPTH+1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PushIn,
    input  logic [DATA_W-1:0]          DataIn,
    input  logic                       PushCoef,
    input  logic [COEF_W-1:0]          CoefIn,
    input  logic                       fifoPullOut,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [CNT_W-1:0]           fifo_count,
    output logic [DATA_W-1:0]          DataOut,
    output logic [NUM_COEF*COEF_W-1:0] coef_bus,
    output logic                       coef_ready,
    output logic                       overflow,
    output logic                       underflow
);
    import fir_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(NUM_COEF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF-1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_W-1:0] hold_q, rdata;
    logic              push_ok, pull_ok;

    sample_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (DataIn),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // A pull frees the slot in the same cycle, so a push at full still lands.
    always_comb begin
        pull_ok  = fifoPullOut & ~empty_q;
        push_ok  = PushIn & ~PushCoef & (~full_q | pull_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pull_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pull_ok)      count_d = count_q + CNT_W'(1);
        else if (pull_ok && !push_ok) count_d = count_q - CNT_W'(1);
        ovf_d = ovf_q | (PushIn & ~PushCoef & ~push_ok);
        unf_d = unf_q | (fifoPullOut & empty_q) | (PushIn & PushCoef);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CNT_W'(DEPTH));
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (!empty_q) hold_q <= rdata;
        end
    end

    // Coefficient loader
    coef_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, widx;
    logic [NUM_COEF-1:0][COEF_W-1:0] coef_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COEF_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (PushCoef) begin
            case (state_q)
                COEF_LOAD: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = COEF_READY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                COEF_READY: begin
                    state_d = COEF_LOAD;
                    idx_d   = IDX_W'(1);
                end
                default: state_d = COEF_LOAD;
            endcase
        end
    end

    always_comb begin
        coef_ready = (state_q == COEF_READY);
        widx       = (state_q == COEF_READY) ? '0 : idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         coef_q       <= '0;
        else if (PushCoef) coef_q[widx] <= CoefIn;
    end

    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign DataOut    = empty_q ? hold_q : rdata;
    assign coef_bus   = coef_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule

// File: tb/tb_fir_input_stage.sv
// Randomized and directed check of fir_input_stage against a queue-based model.
module tb_fir_input_stage;
    localparam int DW = 16, CW = 16, NC = 4, DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          PushIn, PushCoef, fifoPullOut;
    logic [DW-1:0] DataIn;
    logic [CW-1:0] CoefIn;
    logic          fifo_empty, fifo_full, coef_ready, overflow, underflow;
    logic [3:0]    fifo_count;
    logic [DW-1:0] DataOut;
    logic [NC*CW-1:0] coef_bus;

    fir_input_stage #(.DATA_W(DW), .COEF_W(CW), .NUM_COEF(NC), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .PushIn(PushIn), .DataIn(DataIn),
        .PushCoef(PushCoef), .CoefIn(CoefIn), .fifoPullOut(fifoPullOut),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .DataOut(DataOut), .coef_bus(coef_bus), .coef_ready(coef_ready),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Reference model
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_shown;
    logic [CW-1:0] m_coef[NC];
    int            m_pos;
    bit            m_ready, m_ovf, m_unf;

    task automatic model_reset();
        mq.delete();
        m_shown = '0;
        for (int i = 0; i < NC; i++) m_coef[i] = '0;
        m_pos = 0; m_ready = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit push, input logic [DW-1:0] d,
                              input bit pc, input logic [CW-1:0] c, input bit pull);
        bit pull_ok, push_ok;
        pull_ok = pull && (mq.size() > 0);
        push_ok = push && !pc && (mq.size() < DP || pull_ok);
        if (push && pc) m_unf = 1;
        if (pull && mq.size() == 0) m_unf = 1;
        if (push && !pc && !push_ok) m_ovf = 1;
        if (pull_ok) void'(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (mq.size() > 0) m_shown = mq[0];
        if (pc) begin
            if (m_ready) begin
                m_coef[0] = c; m_pos = 1; m_ready = 0;
            end else begin
                m_coef[m_pos] = c; m_pos++;
                if (m_pos == NC) begin m_ready = 1; m_pos = 0; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [63:0] bus;
        bus = '0;
        for (int i = 0; i < NC; i++) bus[i*CW +: CW] = m_coef[i];
        chk("empty", fifo_empty, mq.size() == 0);
        chk("full",  fifo_full,  mq.size() == DP);
        chk("count", fifo_count, mq.size());
        chk("data",  DataOut,    m_shown);
        chk("coef_bus", coef_bus, bus);
        chk("coef_ready", coef_ready, m_ready);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    task automatic step(input bit push, input logic [DW-1:0] d,
                        input bit pc, input logic [CW-1:0] c, input bit pull);
        PushIn = push; DataIn = d; PushCoef = pc; CoefIn = c; fifoPullOut = pull;
        @(posedge clk); #1;
        PushIn = 0; PushCoef = 0; fifoPullOut = 0;
        model_step(push, d, pc, c, pull);
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_empty"}, fifo_empty, 1);
        chk({tag, "_full"},  fifo_full, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_data"},  DataOut, 0);
        chk({tag, "_bus"},   coef_bus, 0);
        chk({tag, "_ready"}, coef_ready, 0);
        chk({tag, "_ovf"},   overflow, 0);
        chk({tag, "_unf"},   underflow, 0);
    endtask

    task automatic do_reset();
        reset = 1; #1;
        check_reset_vals("rst");
        model_reset();
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        reset = 1; PushIn = 0; PushCoef = 0; fifoPullOut = 0; DataIn = '0; CoefIn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("init");
        reset = 0;

        // Basic ordering
        step(1, 16'h0011, 0, 0, 0);
        step(1, 16'h0022, 0, 0, 0);
        step(1, 16'h0033, 0, 0, 0);
        chk("t1_count", fifo_count, 3);
        chk("t1_head", DataOut, 16'h0011);
        step(0, 0, 0, 0, 1); chk("t1_pop1", DataOut, 16'h0022);
        step(0, 0, 0, 0, 1); chk("t1_pop2", DataOut, 16'h0033);
        step(0, 0, 0, 0, 1);
        chk("t1_empty", fifo_empty, 1);
        chk("t1_unf", underflow, 0);

        // Overflow at DEPTH
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
        chk("t2_full", fifo_full, 1);
        chk("t2_count", fifo_count, 8);
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        chk("t2_last", DataOut, 16'h0107);

        // Push+pull at full and while empty
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 16'h0200 + 16'(i), 0, 0, 0);
        step(1, 16'h02AA, 0, 0, 1);
        chk("t3_count", fifo_count, 8);
        chk("t3_head", DataOut, 16'h0201);
        chk("t3_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        chk("t3_tail", DataOut, 16'h02AA);
        step(1, 16'h0301, 0, 0, 1);
        chk("t3_cnt1", fifo_count, 1);
        chk("t3_unf", underflow, 1);

        // Coefficient loading
        do_reset();
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i), 0);
        chk("t4_ready", coef_ready, 1);
        chk("t4_bus", coef_bus, 64'h0004_0003_0002_0001);
        step(0, 0, 1, 16'h000A, 0);
        chk("t4_drop", coef_ready, 0);
        chk("t4_bus2", coef_bus, 64'h0004_0003_0002_000A);

        // Collision
        step(1, 16'h0777, 1, 16'h000B, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_unf", underflow, 1);
        chk("t5_bus", coef_bus, 64'h0004_0003_000B_000A);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 16'h0400 + 16'(i), 0, 0, 0);
        step(0, 0, 1, 16'h0C01, 0);
        step(0, 0, 1, 16'h0C02, 0);
        do_reset();
        step(1, 16'h0055, 0, 0, 0);
        chk("t6_count", fifo_count, 1);
        chk("t6_head", DataOut, 16'h0055);
        step(0, 0, 0, 0, 1);
        chk("t6_empty", fifo_empty, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 99) < 50, 16'($urandom),
                 $urandom_range(0, 99) < 12, 16'($urandom),
                 $urandom_range(0, 99) < 45);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
